// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states, ALU ops, data-processing cmds, cond codes.
// Latency/backpressure: not applicable (package holds declarations only).
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_MOV = 4'b0100;
    localparam logic [3:0] ALU_EOR = 4'b0101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [3:0] alu;
        logic       nowrite;
        logic       flag_nz;
        logic       flag_cv;
    } cmd_dec_t;

    // Unknown commands fall through to a harmless no-write, no-flag op.
    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd, input logic s);
        cmd_dec_t d;
        d = '{alu: ALU_ADD, nowrite: 1'b1, flag_nz: 1'b0, flag_cv: 1'b0};
        case (cmd)
            CMD_ADD: d = '{alu: ALU_ADD, nowrite: 1'b0, flag_nz: s,    flag_cv: s};
            CMD_SUB: d = '{alu: ALU_SUB, nowrite: 1'b0, flag_nz: s,    flag_cv: s};
            CMD_AND: d = '{alu: ALU_AND, nowrite: 1'b0, flag_nz: s,    flag_cv: 1'b0};
            CMD_ORR: d = '{alu: ALU_ORR, nowrite: 1'b0, flag_nz: s,    flag_cv: 1'b0};
            CMD_EOR: d = '{alu: ALU_EOR, nowrite: 1'b0, flag_nz: s,    flag_cv: 1'b0};
            CMD_MOV: d = '{alu: ALU_MOV, nowrite: 1'b0, flag_nz: s,    flag_cv: 1'b0};
            CMD_CMP: d = '{alu: ALU_SUB, nowrite: 1'b1, flag_nz: 1'b1, flag_cv: 1'b1};
            CMD_TST: d = '{alu: ALU_AND, nowrite: 1'b1, flag_nz: 1'b1, flag_cv: 1'b0};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Stored {N,Z,C,V} flag register plus condition-code evaluation against those stored flags.
// Latency: flags update one edge after write enables; condex is combinational. No backpressure.
module cond_unit
    import cpu_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic       flag_wr_nz,
    input  logic       flag_wr_cv,
    output logic       condex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= FLAGS_RST;
        end else begin
            if (flag_wr_nz) flags[3:2] <= aluflags[3:2];
            if (flag_wr_cv) flags[1:0] <= aluflags[1:0];
        end
    end

    assign {n, z, c, v} = flags;

    // Reads the registered value, so a same-cycle write is not visible here.
    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: drives datapath enables/selects per state, owns flags via cond_unit.
// Latency: outputs are combinational from state; MemReady low stalls FETCH, MEMRD and MEMWR in place.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegW,
    output logic       MemW,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl
);

    state_t   state, state_nxt;
    cmd_dec_t dec;
    logic     in_exec;
    logic     condex;
    logic     rd_is_pc;

    assign dec      = decode_cmd(Funct[4:1], Funct[0]);
    assign in_exec  = (state == S_EXECR) || (state == S_EXECI);
    assign rd_is_pc = (Rd == 4'b1111);

    cond_unit #(
        .FLAGS_RST (FLAGS_RST)
    ) u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (Cond),
        .aluflags   (ALUFlags),
        .flag_wr_nz (in_exec & dec.flag_nz),
        .flag_wr_cv (in_exec & dec.flag_cv),
        .condex     (condex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (condex) begin
                    case (Op)
                        2'b01:   state_nxt = S_MEMADR;
                        2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   state_nxt = S_BRANCH;
                        default: state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = MemReady ? S_FETCH : S_MEMWR;
            S_EXECR,
            S_EXECI:  state_nxt = dec.nowrite ? S_FETCH : S_ALUWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = Op;
        RegSrc     = {Op == 2'b01, Op == 2'b10};
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                PCWrite   = rd_is_pc;
                RegW      = ~rd_is_pc;
            end
            S_EXECR:  ALUControl = dec.alu;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dec.alu;
            end
            S_ALUWB: begin
                PCWrite = rd_is_pc;
                RegW    = ~rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle vectors for multicycle_controller, plus a reset-during-store sequence.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Cond = 4'b1110;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'b0;
    logic [3:0] ALUFlags = 4'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] ALUControl;

    always #5 clk = ~clk;

    multicycle_controller #(.FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegW(RegW), .MemW(MemW), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    typedef enum logic [3:0] {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AW, T_BR} tag_t;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] flags;
        logic       mr;
        tag_t       st;
        logic [3:0] pul;   // {PCWrite, IRWrite, RegW, MemW}
        logic [3:0] alu;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [17:0] act;
    assign act = {PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA, ResultSrc, ALUSrcB,
                  ImmSrc, RegSrc, ALUControl};

    // {AdrSrc, ALUSrcA, ResultSrc, ALUSrcB} expected in each state
    function automatic logic [5:0] base(tag_t t);
        case (t)
            T_F, T_D: return 6'b0_1_10_10;
            T_MA:     return 6'b0_0_00_01;
            T_MR:     return 6'b1_0_00_00;
            T_MW:     return 6'b1_0_00_00;
            T_MWB:    return 6'b0_0_01_00;
            T_EI:     return 6'b0_0_00_01;
            T_BR:     return 6'b0_0_10_01;
            default:  return 6'b0_0_00_00;
        endcase
    endfunction

    function automatic logic [17:0] expv(vec_t v);
        return {v.pul, base(v.st), v.op, v.op == 2'b01, v.op == 2'b10, v.alu};
    endfunction

    function automatic vec_t mkv(logic [3:0] cond, logic [1:0] op, logic [5:0] funct,
                                 logic [3:0] rd, logic [3:0] flags, logic mr,
                                 tag_t st, logic [3:0] pul, logic [3:0] alu);
        vec_t v;
        v.cond = cond; v.op = op; v.funct = funct; v.rd = rd; v.flags = flags;
        v.mr = mr; v.st = st; v.pul = pul; v.alu = alu;
        return v;
    endfunction

    task automatic row(logic [3:0] cond, logic [1:0] op, logic [5:0] funct, logic [3:0] rd,
                       logic [3:0] flags, logic mr, tag_t st, logic [3:0] pul, logic [3:0] alu);
        tbl.push_back(mkv(cond, op, funct, rd, flags, mr, st, pul, alu));
    endtask

    task automatic apply(vec_t v);
        Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd;
        ALUFlags = v.flags; MemReady = v.mr;
    endtask

    task automatic check(string nm, logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic step(string nm, vec_t v);
        apply(v);
        #1;
        check(nm, expv(v));
        @(negedge clk);
    endtask

    initial begin
        // ADD R1
        row(4'hE, 2'b00, 6'b001000, 4'd1, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b001000, 4'd1, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b001000, 4'd1, 4'h0, 1'b1, T_ER,  4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b001000, 4'd1, 4'h0, 1'b1, T_AW,  4'b0010, 4'h0);
        // LDR R2: fetch stall, then MEMRD held 4 cycles
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b0, T_F,   4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b1, T_MA,  4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b0, T_MR,  4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b0, T_MR,  4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b0, T_MR,  4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b1, T_MR,  4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 1'b0, T_MWB, 4'b0010, 4'h0);
        // CMP giving Z=1
        row(4'hE, 2'b00, 6'b010101, 4'd0, 4'h4, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b010101, 4'd0, 4'h4, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b010101, 4'd0, 4'h4, 1'b1, T_ER,  4'b0000, 4'h1);
        // BEQ taken, BNE not taken
        row(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_BR,  4'b1000, 4'h0);
        row(4'h1, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'h1, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        // MOV PC, #imm (S=0, flags must stay Z=1)
        row(4'hE, 2'b00, 6'b111010, 4'd15, 4'h0, 1'b1, T_F,  4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b111010, 4'd15, 4'h0, 1'b1, T_D,  4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b111010, 4'd15, 4'h0, 1'b1, T_EI, 4'b0000, 4'h4);
        row(4'hE, 2'b00, 6'b111010, 4'd15, 4'h0, 1'b1, T_AW, 4'b1000, 4'h0);
        row(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_BR,  4'b1000, 4'h0);
        // TST with ALU {N,C}: only N,Z update
        row(4'hE, 2'b00, 6'b010001, 4'd0, 4'hA, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b010001, 4'd0, 4'hA, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b010001, 4'd0, 4'hA, 1'b1, T_ER,  4'b0000, 4'h2);
        row(4'h2, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'h2, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_BR,  4'b1000, 4'h0);
        // unknown cmd with S=1: no write, no flag update
        row(4'hE, 2'b00, 6'b000111, 4'd0, 4'h4, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b000111, 4'd0, 4'h4, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b000111, 4'd0, 4'h4, 1'b1, T_ER,  4'b0000, 4'h0);
        row(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'h4, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_BR,  4'b1000, 4'h0);
        // Cond=1111 never executes; Op=11 returns to fetch
        row(4'hF, 2'b00, 6'b001000, 4'd1, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hF, 2'b00, 6'b001000, 4'd1, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        // STR with MEMWR stall
        row(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, T_MA,  4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b0, T_MW,  4'b0001, 4'h0);
        row(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, T_MW,  4'b0001, 4'h0);
        // LDR PC
        row(4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 1'b1, T_F,  4'b1100, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 1'b1, T_D,  4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 1'b1, T_MA, 4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 1'b1, T_MR, 4'b0000, 4'h0);
        row(4'hE, 2'b01, 6'b011001, 4'd15, 4'h0, 1'b1, T_MWB, 4'b1000, 4'h0);
        // ORRS register, EOR immediate
        row(4'hE, 2'b00, 6'b011001, 4'd4, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b011001, 4'd4, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b011001, 4'd4, 4'h0, 1'b1, T_ER,  4'b0000, 4'h3);
        row(4'hE, 2'b00, 6'b011001, 4'd4, 4'h0, 1'b1, T_AW,  4'b0010, 4'h0);
        row(4'hE, 2'b00, 6'b100010, 4'd5, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b100010, 4'd5, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b100010, 4'd5, 4'h0, 1'b1, T_EI,  4'b0000, 4'h5);
        row(4'hE, 2'b00, 6'b100010, 4'd5, 4'h0, 1'b1, T_AW,  4'b0010, 4'h0);
        // SUBS sets C,V; BVS taken
        row(4'hE, 2'b00, 6'b000101, 4'd6, 4'h3, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'hE, 2'b00, 6'b000101, 4'd6, 4'h3, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'hE, 2'b00, 6'b000101, 4'd6, 4'h3, 1'b1, T_ER,  4'b0000, 4'h1);
        row(4'hE, 2'b00, 6'b000101, 4'd6, 4'h3, 1'b1, T_AW,  4'b0010, 4'h0);
        row(4'h6, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F,   4'b1100, 4'h0);
        row(4'h6, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D,   4'b0000, 4'h0);
        row(4'h6, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_BR,  4'b1000, 4'h0);
        row(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 1'b0, T_F,   4'b0000, 4'h0);

        // reset held: FETCH outputs, state does not advance across an edge
        #2;
        check("reset_outputs", expv(mkv(4'hE, 2'b00, 6'b0, 4'd0, 4'h0, 1'b1, T_F, 4'b1100, 4'h0)));
        @(negedge clk);
        #1;
        check("reset_held", expv(mkv(4'hE, 2'b00, 6'b0, 4'd0, 4'h0, 1'b1, T_F, 4'b1100, 4'h0)));
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("row%0d", i), tbl[i]);
        end

        // reset asserted mid-MEMWR stall
        step("rst_str_f",  mkv(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, T_F,  4'b1100, 4'h0));
        step("rst_str_d",  mkv(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, T_D,  4'b0000, 4'h0));
        step("rst_str_ma", mkv(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b1, T_MA, 4'b0000, 4'h0));
        apply(mkv(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b0, T_MW, 4'b0001, 4'h0));
        #1;
        check("rst_str_mw", expv(mkv(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b0, T_MW, 4'b0001, 4'h0)));
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", expv(mkv(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b0, T_F, 4'b0000, 4'h0)));
        @(posedge clk);
        #1;
        check("rst_hold_edge", expv(mkv(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0, 1'b0, T_F, 4'b0000, 4'h0)));
        @(negedge clk);
        reset = 1'b0;
        // flags back to 0000: BVS not taken
        step("rst_bvs_f",  mkv(4'h6, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_F, 4'b1100, 4'h0));
        step("rst_bvs_d",  mkv(4'h6, 2'b10, 6'b000000, 4'd0, 4'h0, 1'b1, T_D, 4'b0000, 4'h0));
        step("rst_bvs_nt", mkv(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, 1'b1, T_F, 4'b1100, 4'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
